// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit with HI/LO registers.
// Multiplies take MUL_CYCLES busy cycles. Divides use a restoring divider
// that produces one quotient bit per cycle, followed by a sign-fix cycle.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 6-9).
module mdu_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CMAX = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_a;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic               r_ovf;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_is_mthi;
  logic               w_is_mtlo;
  logic               w_is_mac;
  logic               w_mul_go;
  logic               w_div_go;
  logic               w_sgn;
  logic               w_mul_last;
  logic               w_div_last;
  logic [2*WIDTH-1:0] w_ax;
  logic [2*WIDTH-1:0] w_bx;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;
  logic               w_done_nxt;
  logic               w_busy_nxt;

  // Op decode and start qualification; a flushed start is dropped entirely.
  assign w_accept  = start & ~req & (r_state == S_IDLE);
  assign w_is_mul  = (op == 4'd0) | (op == 4'd1);
  assign w_is_div  = (op == 4'd2) | (op == 4'd3);
  assign w_is_mthi = (op == 4'd4);
  assign w_is_mtlo = (op == 4'd5);
`ifdef MDU_MADD_EN
  assign w_is_mac  = (op >= 4'd6) & (op <= 4'd9);
`else
  assign w_is_mac  = 1'b0;
`endif
  assign w_mul_go  = w_accept & (w_is_mul | w_is_mac);
  assign w_div_go  = w_accept & w_is_div;
  // Signed variants (MULT, DIV, MADD, MSUB) all have op[0] clear.
  assign w_sgn     = ~op[0];

  assign w_mul_last = (r_cnt == CW'(MUL_CYCLES - 1));
  assign w_div_last = (r_cnt == CW'(WIDTH - 1));

  // Single 2W x 2W multiplier; sign extension selects signed/unsigned product.
  assign w_ax   = {{WIDTH{w_sgn & a[WIDTH-1]}}, a};
  assign w_bx   = {{WIDTH{w_sgn & b[WIDTH-1]}}, b};
  assign w_prod = w_ax * w_bx;

`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] w_acc_base;
  assign w_acc_base = {r_hi, r_lo};

  // Select plain product or accumulate against the HI/LO value at accept.
  always_comb begin
    case (op)
      4'd6, 4'd7: w_mul_res = w_acc_base + w_prod;
      4'd8, 4'd9: w_mul_res = w_acc_base - w_prod;
      default:    w_mul_res = w_prod;
    endcase
  end
`else
  assign w_mul_res = w_prod;
`endif

  // Divider operand magnitudes and one restoring step.
  assign w_a_mag = (w_sgn & a[WIDTH-1]) ? (~a + ONE) : a;
  assign w_b_mag = (w_sgn & b[WIDTH-1]) ? (~b + ONE) : b;
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_sub   = w_shift[WIDTH-1:0] - r_dvs;

  // Final sign application with the divide-by-zero and overflow cases.
  always_comb begin
    if (r_dz) begin
      w_quo_fix = ALL_ONES;
      w_rem_fix = r_a;
    end else if (r_ovf) begin
      w_quo_fix = MOST_NEG;
      w_rem_fix = {WIDTH{1'b0}};
    end else begin
      w_quo_fix = r_neg_q ? (~r_quo + ONE) : r_quo;
      w_rem_fix = r_neg_r ? (~r_rem + ONE) : r_rem;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_mul_go)      w_state_nxt = S_MUL;
        else if (w_div_go) w_state_nxt = S_DIV;
        else               w_state_nxt = S_IDLE;
      end
      S_MUL: begin
        if (w_mul_last) w_state_nxt = S_IDLE;
        else            w_state_nxt = S_MUL;
      end
      S_DIV: begin
        if (w_div_last) w_state_nxt = S_FIX;
        else            w_state_nxt = S_DIV;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs.
  always_comb begin
    w_hi_nxt   = r_hi;
    w_lo_nxt   = r_lo;
    w_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mthi)      w_hi_nxt = a;
        else if (w_accept && w_is_mtlo) w_lo_nxt = a;
        else                            w_hi_nxt = r_hi;
      end
      S_MUL: begin
        if (w_mul_last) begin
          {w_hi_nxt, w_lo_nxt} = r_prod;
          w_done_nxt           = 1'b1;
        end else begin
          w_done_nxt = 1'b0;
        end
      end
      S_DIV: w_done_nxt = 1'b0;
      S_FIX: begin
        w_hi_nxt   = w_rem_fix;
        w_lo_nxt   = w_quo_fix;
        w_done_nxt = 1'b1;
      end
      default: w_done_nxt = 1'b0;
    endcase
  end

  assign w_busy_nxt = (w_state_nxt != S_IDLE);

  // Registered outputs: HI/LO only change on MTHI/MTLO or op completion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi   <= {WIDTH{1'b0}};
      r_lo   <= {WIDTH{1'b0}};
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_hi   <= w_hi_nxt;
      r_lo   <= w_lo_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Operand latching, cycle counter and the divider iteration.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= {CW{1'b0}};
      r_prod  <= {(2*WIDTH){1'b0}};
      r_quo   <= {WIDTH{1'b0}};
      r_rem   <= {WIDTH{1'b0}};
      r_dvs   <= {WIDTH{1'b0}};
      r_a     <= {WIDTH{1'b0}};
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mul_go) begin
            r_cnt  <= {CW{1'b0}};
            r_prod <= w_mul_res;
          end else if (w_div_go) begin
            r_cnt   <= {CW{1'b0}};
            r_quo   <= w_a_mag;
            r_rem   <= {WIDTH{1'b0}};
            r_dvs   <= w_b_mag;
            r_a     <= a;
            r_neg_q <= w_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r <= w_sgn & a[WIDTH-1];
            r_dz    <= (b == {WIDTH{1'b0}});
            r_ovf   <= w_sgn & (a == MOST_NEG) & (b == ALL_ONES);
          end
        end
        S_MUL: r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        S_DIV: begin
          r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
        end
        S_FIX:   r_cnt <= r_cnt;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter (WIDTH=32, MUL_CYCLES=5).
module tb_mdu_iter;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks = 0;
  int          n_errors = 0;
  int          busy_cnt = 0;
  exp_t        sb[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_iter #(.WIDTH(32), .MUL_CYCLES(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .req(req), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: updates model HI/LO; returns 1 if the op ends with done.
  function automatic bit model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                               output exp_t e);
    logic [63:0] p;
    int sx, sy;
    bit res;
    res = 1'b1;
    sx = x;
    sy = y;
    e.lat = 5;
    case (o)
      4'd0: {m_hi, m_lo} = longint'(sx) * longint'(sy);
      4'd1: {m_hi, m_lo} = {32'd0, x} * {32'd0, y};
      4'd2, 4'd3: begin
        e.lat = 33;
        if (y == 32'd0) begin
          m_hi = x; m_lo = 32'hFFFFFFFF;
        end else if (o == 4'd2 && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
          m_hi = 32'd0; m_lo = 32'h80000000;
        end else if (o == 4'd2) begin
          m_lo = sx / sy; m_hi = sx % sy;
        end else begin
          m_lo = x / y; m_hi = x % y;
        end
      end
      4'd4: begin m_hi = x; res = 1'b0; end
      4'd5: begin m_lo = x; res = 1'b0; end
`ifdef MDU_MADD_EN
      4'd6, 4'd8: begin
        p = longint'(sx) * longint'(sy);
        {m_hi, m_lo} = (o == 4'd6) ? {m_hi, m_lo} + p : {m_hi, m_lo} - p;
      end
      4'd7, 4'd9: begin
        p = {32'd0, x} * {32'd0, y};
        {m_hi, m_lo} = (o == 4'd7) ? {m_hi, m_lo} + p : {m_hi, m_lo} - p;
      end
`endif
      default: res = 1'b0;
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
    return res;
  endfunction

  // Drive one start cycle from a negedge; acc says the bench expects acceptance.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic r, input bit acc);
    exp_t e;
    start = 1'b1; op = o; a = x; b = y; req = r;
    if (acc) begin
      if (model(o, x, y, e)) sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0; req = 1'b0;
  endtask

  // Wait (bounded) until busy drops; returns on the done cycle's negedge.
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_bound", 64'(n < 100), 64'd1);
  endtask

  // Output monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done) begin
      check("done_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("latency", 64'(busy_cnt), 64'(e.lat));
        check("busy_on_done", 64'(busy), 64'd0);
      end
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt++;
    end else begin
      busy_cnt = 0;
    end
  end

  initial begin
    logic [31:0] ph, pl, ra, rb;
    reset = 1'b0; start = 1'b0; req = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Multiply, signed and unsigned, then a back-to-back start on the done cycle
    issue(4'd0, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1);
    wait_idle();
    @(negedge clk);
    check("done_once", 64'(done), 64'd0);
    issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1);
    wait_idle();
    issue(4'd1, 32'd7, 32'd9, 1'b0, 1'b1);
    wait_idle();

    // Divide: signed, overflow, divide-by-zero
    issue(4'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
    wait_idle();
    issue(4'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
    wait_idle();
    issue(4'd3, 32'h00001234, 32'd0, 1'b0, 1'b1);
    wait_idle();
    issue(4'd2, 32'hFFFFFFF0, 32'd0, 1'b0, 1'b1);
    wait_idle();

    // Random mul/div ops
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if ($urandom_range(0, 1) == 0) rb = -rb;
      issue(4'($urandom_range(0, 3)), ra, rb, 1'b0, 1'b1);
      wait_idle();
    end

    // Start with req=1 is dropped
    issue(4'd0, 32'd5, 32'd5, 1'b1, 1'b0);
    check("req_busy", 64'(busy), 64'd0);
    check("req_hi", 64'(hi), 64'(m_hi));
    check("req_lo", 64'(lo), 64'(m_lo));

    // MTHI / no-op
    issue(4'd4, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1);
    check("mthi_hi", 64'(hi), 64'hDEADBEEF);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_lo", 64'(lo), 64'(m_lo));
    issue(4'd12, 32'd1, 32'd2, 1'b0, 1'b1);
    check("nop_busy", 64'(busy), 64'd0);

    // Start during DIV is ignored; HI/LO hold while busy
    ph = m_hi; pl = m_lo;
    issue(4'd2, 32'd100, 32'd7, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    issue(4'd0, 32'd3, 32'd3, 1'b0, 1'b0);
    issue(4'd4, 32'h11111111, 32'd0, 1'b1, 1'b0);
    check("hold_hi", 64'(hi), 64'(ph));
    check("hold_lo", 64'(lo), 64'(pl));
    wait_idle();

    // Reset aborts a running DIVU at busy cycle 10
    issue(4'd3, 32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    @(negedge clk);
    issue(4'd1, 32'd3, 32'd4, 1'b0, 1'b1);
    wait_idle();
    check("mulu_lo", 64'(lo), 64'd12);

    // Multiply-accumulate
    issue(4'd5, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1);
    issue(4'd4, 32'd0, 32'd0, 1'b0, 1'b1);
    check("pre_lo", 64'(lo), 64'hFFFFFFFF);
    issue(4'd7, 32'd1, 32'd1, 1'b0, 1'b1);
`ifdef MDU_MADD_EN
    wait_idle();
    check("maddu_hi", 64'(hi), 64'd1);
    check("maddu_lo", 64'(lo), 64'd0);
    issue(4'd8, 32'd1, 32'd1, 1'b0, 1'b1);
    wait_idle();
    check("msub_hi", 64'(hi), 64'd0);
    check("msub_lo", 64'(lo), 64'hFFFFFFFF);
`else
    check("maddu_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("maddu_busy2", 64'(busy), 64'd0);
    check("maddu_hi", 64'(hi), 64'd0);
    check("maddu_lo", 64'(lo), 64'hFFFFFFFF);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
